// File: rtl/tmds_pkg.sv
// Shared TMDS types and constants: symbol width, control codes, clock-lane pattern.
package tmds_pkg;

  localparam int unsigned SYM_W     = 10;
  localparam int unsigned BIT_CNT_W = 4;

  typedef logic [SYM_W-1:0] tmds_sym_t;

  typedef struct packed {
    tmds_sym_t r;
    tmds_sym_t g;
    tmds_sym_t b;
  } tmds_triple_t;

  localparam tmds_sym_t TMDS_CTRL_00 = 10'b1101010100;
  localparam tmds_sym_t TMDS_CTRL_01 = 10'b0010101011;
  localparam tmds_sym_t TMDS_CTRL_10 = 10'b0101010100;
  localparam tmds_sym_t TMDS_CTRL_11 = 10'b1010101011;

  // Written in transmit order: leftmost bit leaves first (bit_cnt 0).
  localparam tmds_sym_t TMDS_CLK_PATTERN = 10'b1111100000;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SYM_W - 1);

endpackage

// File: rtl/tmds_sym_if.sv
// Symbol-triple handshake between the encoder stage and the serializer.
interface tmds_sym_if;

  tmds_pkg::tmds_sym_t sym_b;
  tmds_pkg::tmds_sym_t sym_g;
  tmds_pkg::tmds_sym_t sym_r;
  logic                sym_valid;
  logic                sym_ready;

  modport master (output sym_b, sym_g, sym_r, sym_valid, input  sym_ready);
  modport slave  (input  sym_b, sym_g, sym_r, sym_valid, output sym_ready);

endinterface

// File: rtl/tmds_lane_shift.sv
// One TMDS lane: 10-bit load/shift register, LSB first, with a registered serial bit.
module tmds_lane_shift
  import tmds_pkg::*;
#(
  parameter tmds_sym_t RESET_SYM = TMDS_CTRL_00
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load,
  input  tmds_sym_t load_sym,
  output logic      ser
);

  tmds_sym_t sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= RESET_SYM;
      ser <= 1'b0;
    end else begin
      ser <= sr[0];
      if (load) sr <= load_sym;
      else      sr <= {1'b0, sr[SYM_W-1:1]};
    end
  end

endmodule

// File: rtl/tmds_serializer.sv
// Three-lane TMDS serializer with one-entry holding buffer, clock-lane pattern and underrun stats.
module tmds_serializer
  import tmds_pkg::*;
#(
  parameter tmds_sym_t   FILL_SYM = TMDS_CTRL_00,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  tmds_sym_if.slave        sym,
  output logic             pix_stb,
  output logic             tmds_b,
  output logic             tmds_g,
  output logic             tmds_r,
  output logic             tmds_clk,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_cnt
);

  localparam tmds_triple_t FILL_TRIPLE = {FILL_SYM, FILL_SYM, FILL_SYM};

  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  tmds_triple_t         hold, hold_nxt;
  logic                 hold_full, hold_full_nxt;
  logic                 ready_q, ready_nxt;
  logic                 pix_q, pix_nxt;
  logic                 clk_q, clk_nxt;
  logic                 under_q, under_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic                 load_c;
  logic                 send_hold_c;
  tmds_triple_t         lane_sym_c;

  // Next-state: bit counter, holding buffer, handshake and underrun statistics.
  always_comb begin
    load_c        = (bit_cnt == LAST_BIT);
    bit_cnt_nxt   = load_c ? '0 : BIT_CNT_W'(bit_cnt + BIT_CNT_W'(1));
    send_hold_c   = hold_full && ena;
    lane_sym_c    = send_hold_c ? hold : FILL_TRIPLE;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    under_nxt     = under_q;
    cnt_nxt       = cnt_q;

    if (load_c) begin
      hold_full_nxt = 1'b0;
      if (!send_hold_c && ena) begin
        under_nxt = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) cnt_nxt = CNT_W'(cnt_q + CNT_W'(1));
      end
    end

    // Capture after the load decision so a word accepted on the load cycle waits a full word.
    if (sym.sym_valid && ready_q) begin
      hold_nxt      = '{r: sym.sym_r, g: sym.sym_g, b: sym.sym_b};
      hold_full_nxt = 1'b1;
    end

    ready_nxt = ena && !hold_full_nxt;
    pix_nxt   = (bit_cnt_nxt == LAST_BIT);
    clk_nxt   = TMDS_CLK_PATTERN[BIT_CNT_W'(LAST_BIT - bit_cnt)];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      ready_q   <= 1'b0;
      pix_q     <= 1'b0;
      clk_q     <= 1'b0;
      under_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      bit_cnt   <= bit_cnt_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
      ready_q   <= ready_nxt;
      pix_q     <= pix_nxt;
      clk_q     <= clk_nxt;
      under_q   <= under_nxt;
      cnt_q     <= cnt_nxt;
    end
  end

  tmds_lane_shift #(.RESET_SYM(FILL_SYM)) u_lane_b (
    .clk(clk), .rst_n(rst_n), .load(load_c), .load_sym(lane_sym_c.b), .ser(tmds_b)
  );
  tmds_lane_shift #(.RESET_SYM(FILL_SYM)) u_lane_g (
    .clk(clk), .rst_n(rst_n), .load(load_c), .load_sym(lane_sym_c.g), .ser(tmds_g)
  );
  tmds_lane_shift #(.RESET_SYM(FILL_SYM)) u_lane_r (
    .clk(clk), .rst_n(rst_n), .load(load_c), .load_sym(lane_sym_c.r), .ser(tmds_r)
  );

  assign sym.sym_ready = ready_q;
  assign pix_stb       = pix_q;
  assign tmds_clk      = clk_q;
  assign underrun      = under_q;
  assign underrun_cnt  = cnt_q;

endmodule

// File: tb/tb_tmds_serializer.sv
// Bench for tmds_serializer: word-slot reference model of the serial streams and statistics.
module tb_tmds_serializer;

  localparam logic [9:0] FILL = 10'b1101010100;
  localparam int unsigned CW  = 8;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          pix_stb, tmds_b, tmds_g, tmds_r, tmds_clk, underrun;
  logic [CW-1:0] underrun_cnt;

  tmds_sym_if sym_if ();

  tmds_serializer #(.FILL_SYM(FILL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sym(sym_if),
    .pix_stb(pix_stb), .tmds_b(tmds_b), .tmds_g(tmds_g), .tmds_r(tmds_r),
    .tmds_clk(tmds_clk), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: time in edges since reset, word currently on the wire, buffer contents.
  int         m_t;
  logic [9:0] cur_b, cur_g, cur_r;
  logic [9:0] hld_b, hld_g, hld_r;
  logic       m_full, m_ready, m_under;
  int         m_cnt;
  logic       e_b, e_g, e_r, e_clk, e_pix;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0;
    cur_b = FILL; cur_g = FILL; cur_r = FILL;
    hld_b = '0; hld_g = '0; hld_r = '0;
    m_full = 1'b0; m_ready = 1'b0; m_under = 1'b0; m_cnt = 0;
    e_b = 1'b0; e_g = 1'b0; e_r = 1'b0; e_clk = 1'b0; e_pix = 1'b0;
  endtask

  task automatic model_step();
    int  k;
    logic acc;
    acc = sym_if.sym_valid && m_ready;
    m_t++;
    k = (m_t - 1) % 10;
    e_b   = cur_b[k];
    e_g   = cur_g[k];
    e_r   = cur_r[k];
    e_clk = (k < 5);
    e_pix = ((m_t % 10) == 9);
    if ((m_t % 10) == 0) begin
      if (m_full && ena) begin
        cur_b = hld_b; cur_g = hld_g; cur_r = hld_r;
      end else begin
        cur_b = FILL; cur_g = FILL; cur_r = FILL;
        if (ena) begin
          m_under = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
      m_full = 1'b0;
    end
    if (acc) begin
      hld_b = sym_if.sym_b; hld_g = sym_if.sym_g; hld_r = sym_if.sym_r;
      m_full = 1'b1;
    end
    m_ready = ena && !m_full;
  endtask

  task automatic check_all();
    check("tmds_b",       32'(tmds_b),       32'(e_b));
    check("tmds_g",       32'(tmds_g),       32'(e_g));
    check("tmds_r",       32'(tmds_r),       32'(e_r));
    check("tmds_clk",     32'(tmds_clk),     32'(e_clk));
    check("pix_stb",      32'(pix_stb),      32'(e_pix));
    check("sym_ready",    32'(sym_if.sym_ready), 32'(m_ready));
    check("underrun",     32'(underrun),     32'(m_under));
    check("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [9:0] b, input logic [9:0] g, input logic [9:0] r);
    sym_if.sym_valid = v;
    sym_if.sym_b = b; sym_if.sym_g = g; sym_if.sym_r = r;
  endtask

  logic [9:0] got;

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    drive(1'b0, '0, '0, '0);
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: fill words, clock pattern, two underruns after two loads.
    got = '0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i < 10) got[i] = tmds_b;
      if (i == 19) check("cnt_after_two_loads", 32'(underrun_cnt), 32'd2);
    end
    check("first_word_is_fill", 32'(got), 32'(FILL));

    // Continuous valid stream with fixed symbols.
    drive(1'b1, 10'h3FF, 10'h000, 10'h155);
    for (int i = 0; i < 60; i++) tick();

    // Drain, then present a word only on a load cycle with the buffer empty.
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 20; i++) tick();
    for (int i = 0; i < 10 && (m_t % 10) != 9; i++) tick();
    check("buffer_empty_before_load_push", 32'(sym_if.sym_ready), 32'd1);
    drive(1'b1, 10'h2C7, 10'h1A5, 10'h0F3);
    tick();
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 25; i++) tick();

    // ena dropped with the buffer full: held word discarded, no underrun counted.
    drive(1'b1, 10'h3A1, 10'h05C, 10'h2E2);
    for (int i = 0; i < 12 && !m_full; i++) tick();
    drive(1'b0, '0, '0, '0);
    ena = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("ready_low_while_disabled", 32'(sym_if.sym_ready), 32'd0);
    ena = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // Randomized traffic with occasional disable.
    for (int i = 0; i < 400; i++) begin
      ena = ($urandom_range(0, 15) != 0);
      drive(1'($urandom_range(0, 1)), 10'($urandom), 10'($urandom), 10'($urandom));
      tick();
    end

    // Long underrun run: counter saturates.
    ena = 1'b1;
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 3000; i++) tick();
    check("cnt_saturated", 32'(underrun_cnt), 32'd255);
    check("underrun_sticky", 32'(underrun), 32'd1);

    // Reset mid-word at bit_cnt 4 with data pending from upstream.
    for (int i = 0; i < 10 && (m_t % 10) != 4; i++) tick();
    drive(1'b1, 10'h155, 10'h2AA, 10'h0F0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 20; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmds_serializer.md
# tmds_serializer

Bit-rate TMDS serializer between the HDMI pixel/encoder logic and the per-lane `ELVDS_OBUF` differential buffers on the Nano 9K build. It accepts one 10-bit symbol per lane (blue, green, red) via a valid/ready handshake into a one-entry holding buffer. It shifts each symbol out LSB-first at one bit per `clk`, and generates the matching TMDS clock-lane pattern. When no symbol is ready at a word boundary it inserts a control fill symbol and counts the underrun.

## Interface
Parameters:
- `FILL_SYM`, default `10'b1101010100` (control code C1C0=00): symbol sent on all three lanes on underrun, while `ena` is low, and after reset.
- `CNT_W`, default 8: width of the saturating underrun counter.

Ports:
- `clk` input 1: bit clock (126 MHz PLL output); single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: serializer enable; low forces fill symbols and deasserts `sym_ready`.
- `sym_b`, `sym_g`, `sym_r` input 10 each: encoded TMDS symbols, bit 0 transmitted first.
- `sym_valid` input 1: the symbol triple is valid.
- `sym_ready` output 1: holding buffer empty and `ena` high.
- `pix_stb` output 1: one-cycle pulse on the word-load cycle; upstream pixel-rate clock enable.
- `tmds_b`, `tmds_g`, `tmds_r` output 1 each: serial lane bits to the LVDS buffers.
- `tmds_clk` output 1: clock-lane bit, pattern `1111100000` per word.
- `underrun` output 1: sticky flag, set on any fill insertion while `ena`=1.
- `underrun_cnt` output CNT_W: saturating count of fill insertions while `ena`=1.

## Operation
- Bit counter `bit_cnt` cycles 0..9, free-running after reset regardless of `ena`.
- Load cycle: `bit_cnt`==9. On that edge:
  - Each lane shift register loads the holding word if the buffer is full and `ena`=1, then the buffer empties.
  - Otherwise it loads `FILL_SYM`. If `ena`=1, `underrun` is set and `underrun_cnt` increments, saturating at all-ones.
  - `bit_cnt` wraps to 0.
- All other cycles: shift registers shift right by one bit.
- Handshake: a transfer occurs when `sym_valid && sym_ready`. The triple is captured into the holding buffer and marks it full.
- `sym_ready` = `!hold_full && ena`, driven from registered state only and with no combinational path from `sym_valid`.
- No bypass: a word accepted on a load cycle is held until the next load. The current load still uses whatever was in the buffer at the start of the cycle, which is fill if the buffer was empty.
- `ena` falling with the buffer full: the held word is discarded at the next load cycle and fill is sent; no underrun is counted.
- `pix_stb` = (`bit_cnt`==9), registered-state decode.
- `tmds_clk` bit = 1 for `bit_cnt` 0..4 and 0 for 5..9, delayed identically to the data lanes.

## Timing
- Reset values:
  - Outputs: `tmds_*`=0, `tmds_clk`=0, `sym_ready`=0 (it is 1 from the first cycle after reset release if `ena`=1), `pix_stb`=0, `underrun`=0, `underrun_cnt`=0.
  - Internal state: `bit_cnt`=0, shift registers=`FILL_SYM`, holding buffer empty.
- Lane outputs are registered from shift-register bit 0, giving 1 cycle of output latency. Symbol bit k appears on `tmds_*` at cycle L+1+k, where L is the cycle after the load edge.
- The first 10 bits after reset are always `FILL_SYM`. The earliest user symbol starts output at cycle 11 after reset release.
- Throughput: one symbol triple per 10 cycles. The upstream stage may present the next word any time after `sym_ready` rises.
- Reset asserted mid-word: all state clears immediately (asynchronous reset). The partially sent symbol is truncated; no underrun is counted.

## Structure
- Shared package `tmds_pkg`:
  - `SYM_W`=10.
  - `tmds_sym_t` typedef.
  - Control-code constants: `TMDS_CTRL_00`=1101010100, `_01`=0010101011, `_10`=0101010100, `_11`=1010101011.
  - `TMDS_CLK_PATTERN`=1111100000.
- One natural sub-module: `tmds_lane_shift`, a 10-bit load/shift register with a registered output bit. It is instantiated three times; the counter, handshake and statistics stay in the top.

## Test plan
- Reset release with `ena`=1, `sym_valid`=0 for 30 cycles: every lane serial stream repeats 0010101011 (1101010100 sent LSB first); `underrun_cnt` = 2 after two load cycles (fill after reset is not counted); `tmds_clk` repeats 1111100000.
- Continuous valid stream `sym_b`=0x3FF, `sym_g`=0x000, `sym_r`=0x155: lanes carry ten 1s, ten 0s and alternating 1010101010 respectively; `sym_ready` never blocks for more than 10 cycles; `underrun_cnt` stays at its post-reset value.
- `sym_valid` asserted only on a load cycle with the buffer empty: that word is accepted and transmitted one word later; fill is sent in between; the counter increments by 1.
- `ena` dropped with the buffer full: the next word sent is fill, `sym_ready`=0, and the counter is unchanged.
- 300 consecutive underruns with `CNT_W`=8: `underrun_cnt` saturates at 255 and `underrun`=1.
- `rst_n` pulsed at `bit_cnt`=4: outputs go to 0 immediately; after release the counter restarts at 0, with the first fill word followed by pending data.
